// File: rtl/serial_byte_assembler_if.sv
// ============================================================================
//  Module   : serial_byte_assembler_if
//  Purpose  : Bundles the serial input pair and the valid/ready word output of
//             the serial byte assembler.
//  Signals  : sin       - serial data bit
//             sin_valid - sin is sampled on the rising edge when high
//             D         - assembled word
//             d_valid   - D holds an unconsumed word
//             d_ready   - consumer accepts D when d_valid && d_ready
//  Modports : slave  - the assembler (consumes sin, produces D)
//             master - the environment (drives sin, consumes D)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_byte_assembler_if #(
  parameter int WIDTH = 8
) ();

  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] D;
  logic             d_valid;
  logic             d_ready;

  modport slave (
    input  sin,
    input  sin_valid,
    input  d_ready,
    output D,
    output d_valid
  );

  modport master (
    output sin,
    output sin_valid,
    output d_ready,
    input  D,
    input  d_valid
  );

endinterface

`default_nettype wire

// File: rtl/serial_byte_assembler.sv
// ============================================================================
//  Module   : serial_byte_assembler
//  Purpose  : Shifts in a serial bit stream, one bit per qualified clock, and
//             presents each completed word through a one-entry valid/ready
//             output buffer. A word completing while the buffer is still held
//             by the consumer is dropped and flagged by a sticky overrun.
//  Ports    : clk         - system clock, rising edge
//             clr         - asynchronous active-low reset
//             bus         - serial input / word output (slave modport)
//             flush       - synchronous discard of a partial word
//             bit_cnt     - number of bits currently in the shift register
//             overrun     - sticky, a completed word was dropped
//             overrun_clr - synchronous clear of overrun (a new drop wins)
//  Params   : WIDTH       - bits per word, >= 2
//             MSB_FIRST   - 1: first bit lands in WIDTH-1, 0: lands in bit 0
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_byte_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic                       clk,
  input  wire logic                       clr,
  serial_byte_assembler_if.slave          bus,
  input  wire logic                       flush,
  output logic [$clog2(WIDTH)-1:0]        bit_cnt,
  output logic                            overrun,
  input  wire logic                       overrun_clr
);

  localparam int               c_cw   = $clog2(WIDTH);
  localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);

  // Buffer state; d_valid is a direct decode of this flop.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_sr;
  logic [c_cw-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_d;
  logic              r_overrun;

  logic [WIDTH-1:0]  w_shifted;
  logic              w_shift;
  logic              w_complete;
  logic              w_accept;

  // Shift register contents after taking in the current bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], bus.sin};
    end else begin : g_lsb_first
      assign w_shifted = {bus.sin, r_sr[WIDTH-1:1]};
    end
  endgenerate

  // flush takes priority over a simultaneous sample, so it can never complete.
  assign w_shift    = bus.sin_valid & ~flush;
  assign w_complete = w_shift & (r_cnt == c_last);
  assign w_accept   = (r_state == ST_FULL) & bus.d_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= ST_EMPTY;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_d       <= '0;
      r_overrun <= 1'b0;
    end else begin
      // Shift path runs independently of the output buffer.
      if (flush) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sr  <= w_shifted;
        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
      end

      // Output buffer. When full, a completing word can only be loaded if the
      // old one leaves on the same edge; otherwise it is dropped.
      case (r_state)
        ST_EMPTY: begin
          if (w_complete) begin
            r_d     <= w_shifted;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_complete) begin
            if (w_accept) begin
              r_d <= w_shifted;
            end
          end else if (w_accept) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      // Sticky drop flag; a drop on the clearing edge keeps it set.
      if (w_complete && (r_state == ST_FULL) && !w_accept) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.D       = r_d;
  assign bus.d_valid = (r_state == ST_FULL);
  assign bit_cnt     = r_cnt;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: doc/serial_byte_assembler.md
Name: serial_byte_assembler

Overview:
- Upstream feeder for the 8-bit holding register.
- Collects a serial bit stream, 1 bit per qualified clock, into a parallel word.
- Presents each completed word on a valid/ready output port. The register stage captures the word on the accept cycle.
- A one-entry output buffer lets shifting continue while the consumer is busy. Overrun is detected and flagged.

Parameters:
- WIDTH, 8, bits per assembled word. Must be ≥ 2.
- MSB_FIRST, 1. 1 = the first received bit lands in bit WIDTH-1; 0 = the first received bit lands in bit 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this rising edge when high.
- flush  input  1  synchronous; discards a partially assembled word.
- D  output  WIDTH  assembled word; drives the holding register's D input.
- d_valid  output  1  D holds an unconsumed word.
- d_ready  input  1  consumer accepts D this cycle when d_valid && d_ready.
- bit_cnt  output  $clog2(WIDTH)  number of bits currently in the shift register.
- overrun  output  1  sticky; a completed word was dropped.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (clr low, asynchronous, any cycle):
  - shift register = 0, bit_cnt = 0, D = 0, d_valid = 0, overrun = 0.
  - A partial word or a pending output word is lost. No output glitch-pulse on release.
- Internal state:
  - Shift register sr[WIDTH-1:0].
  - Counter bit_cnt, 0..WIDTH-1.
  - Output buffer D with flag d_valid.
- FSM, two states, encoded by d_valid:
  - EMPTY: d_valid = 0.
  - FULL: d_valid = 1.
  - Shift counter runs independently of the FSM.
- Shift (sin_valid = 1, flush = 0):
  - MSB_FIRST = 1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST = 0: sr <= {sin, sr[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion:
  - Occurs on a shift edge where bit_cnt == WIDTH-1.
  - The completed word is {shifted value including this bit}. bit_cnt wraps to 0 on the same edge.
- Transfer on completion:
  - If the buffer is EMPTY, or FULL with d_ready = 1 on that same edge: D <= completed word, d_valid <= 1.
  - Latency: D and d_valid are visible the cycle after the last bit is sampled.
  - Simultaneous accept and complete: the old word is consumed and the new word loaded on the same edge, with no bubble. d_valid stays 1.
  - If FULL and d_ready = 0: the completed word is dropped, D is unchanged, overrun <= 1.
- Accept without completion: d_valid && d_ready moves FULL→EMPTY. D keeps its last value (don't-care to the consumer).
- d_ready while d_valid = 0: ignored.
- flush = 1:
  - sr <= 0, bit_cnt <= 0.
  - sin_valid on the same edge is ignored; no completion can occur.
  - The output buffer and overrun are unaffected.
  - A handshake on the same edge is still honoured.
- overrun:
  - Set on a drop, cleared by overrun_clr.
  - Set and clear on the same edge: set wins.
- D is stable while d_valid = 1 and not accepted (hold rule). The consumer may capture on any clk edge with the handshake.

Test Plan:
- Reset, then MSB_FIRST = 1, WIDTH = 8, send 1,0,1,0,0,1,0,1 with sin_valid held high and d_ready = 0 → D = 8'hA5, d_valid = 1 one cycle after the 8th bit, bit_cnt = 0.
- MSB_FIRST = 0, same bit sequence → D = 8'hA5 (bit-reversed stream 1,0,1,0,0,1,0,1 LSB-first yields 0xA5). Then the stream for 0x3C, LSB first → 8'h3C.
- Back-to-back: keep d_ready = 0 after 0xA5, send 8 more bits (0xFF) → D stays 0xA5, overrun = 1. Pulse overrun_clr → overrun = 0.
- Simultaneous: d_valid = 1 with 0x11, assert d_ready on the edge completing 0x22 → D = 0x22 next cycle, d_valid stays 1, overrun = 0.
- Send 3 bits, assert flush, then 8 bits of 0x5A → D = 0x5A, no contamination from the partial word.
- Drive clr low mid-word (bit_cnt = 5) with d_valid = 1 → all outputs 0 immediately, with no clk edge needed. After release, the next 8 bits form a clean word.
